// File: rtl/viterbi_decoder_tb.sv
// ---------------------------------------------------------------------------
// viterbi_decoder_tb
//   Hard-decision Viterbi decoder for the tail-biting rate-1/3, K=7 code
//   (generators 133/171/165 octal). It pops one byte from each of the three
//   coded sub-block FIFOs every 8 trellis steps and runs add-compare-select
//   over the 64 states, one next-state per cycle. Survivor words are stored
//   in a survivor RAM. A traceback then rebuilds the payload, and the payload
//   is emitted MSB-first as bytes into a downstream FIFO.
//
// Parameters
//   K_SMALL / K_LARGE : block lengths in bits (multiples of 8). K_LARGE sizes
//                       both RAMs.
//   PM_W              : path-metric width.
//
// Ports
//   clk, reset        : clock; synchronous active-high reset
//   start             : one-cycle pulse that begins a block (only when idle)
//   blk_len_sel       : latched on start, 0 = K_SMALL, 1 = K_LARGE
//   in_empty[2:0]     : empty flags of the d0/d1/d2 FIFOs
//   in_rdreq          : pops all three FIFOs together
//   in_q0/in_q1/in_q2 : coded bytes, valid the cycle after in_rdreq
//   out_full          : downstream FIFO full
//   out_wrreq         : writes out_data into the downstream FIFO
//   out_data          : decoded byte, bit 7 = earliest info bit
//   busy              : high from the accepted start until done
//   done              : one-cycle pulse after the last out_wrreq
// ---------------------------------------------------------------------------
module viterbi_decoder_tb #(
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144,
    parameter int PM_W    = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       blk_len_sel,
    input  logic [2:0] in_empty,
    output logic       in_rdreq,
    input  logic [7:0] in_q0,
    input  logic [7:0] in_q1,
    input  logic [7:0] in_q2,
    input  logic       out_full,
    output logic       out_wrreq,
    output logic [7:0] out_data,
    output logic       busy,
    output logic       done
);

    localparam int N_W  = $clog2(K_LARGE + 1);   // step counter width
    localparam int SA_W = $clog2(K_LARGE);       // survivor RAM address width
    localparam int BA_W = $clog2(K_LARGE / 8);   // decoded-byte RAM address width

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_ACS, S_TB, S_OUT, S_DONE
    } state_t;

    state_t            r_state;
    logic              r_busy, r_done, r_len_sel;
    logic [N_W-1:0]    r_n;                  // trellis step
    logic [5:0]        r_ns;                 // next-state being computed in ACS
    logic [7:0]        r_q0, r_q1, r_q2;     // current coded bytes
    logic              r_bank;               // path-metric bank read this step
    logic [PM_W-1:0]   r_pm [2][64];
    logic [PM_W-1:0]   r_min_prev;           // minimum of last step's metrics
    logic [PM_W-1:0]   r_min_run;            // running minimum in this step
    logic [5:0]        r_best_run;           // state holding r_min_run
    logic [62:0]       r_dec_word;           // decisions for ns = 0..62
    logic [63:0]       r_surv_ram [K_LARGE];
    logic [63:0]       r_surv_q;
    logic [7:0]        r_dec_ram [K_LARGE/8];
    logic [5:0]        r_tb_state;
    logic              r_tb_prime;           // first TB cycle fetches word K-1
    logic [7:0]        r_byte;               // traceback byte assembly
    logic [BA_W-1:0]   r_out_idx;
    logic              r_out_vld;            // out_data holds byte r_out_idx
    logic [7:0]        r_out_data;

    logic [N_W-1:0]    w_k;
    logic [BA_W-1:0]   w_last_byte;
    logic [5:0]        w_pa, w_pb;
    logic [2:0]        w_rx;
    logic [1:0]        w_bm_a, w_bm_b;
    logic [PM_W:0]     w_sum_a, w_sum_b;
    logic              w_pick_b;
    logic [PM_W-1:0]   w_pm_new;
    logic              w_new_min;
    logic [PM_W-1:0]   w_step_min;
    logic [5:0]        w_step_best;
    logic              w_in_rdreq, w_out_fire, w_tb_bit, w_dec_we;
    logic [SA_W-1:0]   w_surv_raddr;
    logic [BA_W-1:0]   w_dec_raddr;

    // Expected {d2,d1,d0} for the branch from state s with input u.
    // s = {u(n-1)..u(n-6)}, so s[5] = u(n-1) and s[0] = u(n-6).
    function automatic logic [2:0] branch_code(input logic u, input logic [5:0] s);
        logic d0, d1, d2;
        d0 = u ^ s[4] ^ s[3] ^ s[1] ^ s[0];
        d1 = u ^ s[5] ^ s[4] ^ s[3] ^ s[0];
        d2 = u ^ s[5] ^ s[4] ^ s[2] ^ s[0];
        return {d2, d1, d0};
    endfunction

    function automatic logic [1:0] hamming3(input logic [2:0] x);
        return 2'(x[0]) + 2'(x[1]) + 2'(x[2]);
    endfunction

    assign w_k         = r_len_sel ? N_W'(K_LARGE) : N_W'(K_SMALL);
    assign w_last_byte = BA_W'((w_k >> 3) - N_W'(1));

    // ACS datapath: the two predecessors of r_ns differ only in their LSB.
    assign w_pa    = {r_ns[4:0], 1'b0};
    assign w_pb    = {r_ns[4:0], 1'b1};
    assign w_rx    = {r_q2[r_n[2:0]], r_q1[r_n[2:0]], r_q0[r_n[2:0]]};
    assign w_bm_a  = hamming3(branch_code(r_ns[5], w_pa) ^ w_rx);
    assign w_bm_b  = hamming3(branch_code(r_ns[5], w_pb) ^ w_rx);
    // Subtracting the previous step's minimum on read keeps the stored metrics small.
    assign w_sum_a = {1'b0, r_pm[r_bank][w_pa] - r_min_prev} + (PM_W+1)'(w_bm_a);
    assign w_sum_b = {1'b0, r_pm[r_bank][w_pb] - r_min_prev} + (PM_W+1)'(w_bm_b);
    assign w_pick_b    = (w_sum_b < w_sum_a);          // on a tie, the LSB-0 predecessor wins
    assign w_pm_new    = w_pick_b ? w_sum_b[PM_W-1:0] : w_sum_a[PM_W-1:0];
    // The strict compare keeps the lowest state index on ties.
    assign w_new_min   = (r_ns == 6'd0) || (w_pm_new < r_min_run);
    assign w_step_min  = w_new_min ? w_pm_new : r_min_run;
    assign w_step_best = w_new_min ? r_ns : r_best_run;

    // The handshakes are gated by the live FIFO flags, so a pop or a push
    // never happens in a cycle when the FIFO is blocked.
    assign w_in_rdreq = (r_state == S_FETCH) && (r_n[2:0] == 3'd0) && (in_empty == 3'b000);
    assign w_out_fire = (r_state == S_OUT) && r_out_vld && !out_full;

    assign w_tb_bit = r_tb_state[5];
    assign w_dec_we = (r_state == S_TB) && !r_tb_prime && (r_n[2:0] == 3'd0);

    // NOTE: every signal written in always_comb gets a default first, so that no path infers a latch.
    always_comb begin
        w_surv_raddr = SA_W'(r_n);
        // After the priming cycle, fetch the word for the step that traceback processes next.
        if (r_state == S_TB && !r_tb_prime)
            w_surv_raddr = SA_W'(r_n - N_W'(1));
        w_dec_raddr = r_out_idx;
        if (w_out_fire)
            w_dec_raddr = r_out_idx + BA_W'(1);
    end

    assign in_rdreq  = w_in_rdreq;
    assign out_wrreq = w_out_fire;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;

    // NOTE: the RAMs and metric banks have no reset; a start clears the metrics, and the RAMs are always written before they are read.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && start) begin
            for (int i = 0; i < 64; i++) begin
                r_pm[0][i] <= '0;
                r_pm[1][i] <= '0;
            end
        end else if (r_state == S_ACS) begin
            r_pm[~r_bank][r_ns] <= w_pm_new;
        end
    end

    always_ff @(posedge clk) begin
        if (r_state == S_ACS && r_ns == 6'd63)
            r_surv_ram[SA_W'(r_n)] <= {w_pick_b, r_dec_word};
        r_surv_q <= r_surv_ram[w_surv_raddr];
    end

    always_ff @(posedge clk) begin
        if (w_dec_we)
            r_dec_ram[BA_W'(r_n >> 3)] <= {w_tb_bit, r_byte[7:1]};
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_len_sel  <= 1'b0;
            r_n        <= '0;
            r_ns       <= '0;
            r_q0       <= '0;
            r_q1       <= '0;
            r_q2       <= '0;
            r_bank     <= 1'b0;
            r_min_prev <= '0;
            r_min_run  <= '0;
            r_best_run <= '0;
            r_dec_word <= '0;
            r_tb_state <= '0;
            r_tb_prime <= 1'b0;
            r_byte     <= '0;
            r_out_idx  <= '0;
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_len_sel  <= blk_len_sel;
                        r_busy     <= 1'b1;
                        r_n        <= '0;
                        r_ns       <= '0;
                        r_bank     <= 1'b0;
                        r_min_prev <= '0;
                        r_state    <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (r_n[2:0] != 3'd0)
                        r_state <= S_ACS;
                    else if (w_in_rdreq)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_q0    <= in_q0;
                    r_q1    <= in_q1;
                    r_q2    <= in_q2;
                    r_state <= S_ACS;
                end
                S_ACS: begin
                    r_dec_word <= {w_pick_b, r_dec_word[62:1]};
                    r_min_run  <= w_step_min;
                    r_best_run <= w_step_best;
                    r_ns       <= r_ns + 6'd1;
                    if (r_ns == 6'd63) begin
                        r_bank     <= ~r_bank;
                        r_min_prev <= w_step_min;
                        if (r_n == w_k - N_W'(1)) begin
                            r_tb_state <= w_step_best;
                            r_tb_prime <= 1'b1;
                            r_state    <= S_TB;
                        end else begin
                            r_n     <= r_n + N_W'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                S_TB: begin
                    if (r_tb_prime) begin
                        r_tb_prime <= 1'b0;
                    end else begin
                        r_tb_state <= {r_tb_state[4:0], r_surv_q[r_tb_state]};
                        r_byte     <= {w_tb_bit, r_byte[7:1]};
                        if (r_n == '0) begin
                            r_out_idx <= '0;
                            r_out_vld <= 1'b0;
                            r_state   <= S_OUT;
                        end else begin
                            r_n <= r_n - N_W'(1);
                        end
                    end
                end
                S_OUT: begin
                    r_out_data <= r_dec_ram[w_dec_raddr];
                    r_out_vld  <= 1'b1;
                    if (w_out_fire) begin
                        if (r_out_idx == w_last_byte)
                            r_state <= S_DONE;
                        else
                            r_out_idx <= r_out_idx + BA_W'(1);
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_viterbi_decoder_tb.sv
// ---------------------------------------------------------------------------
// tb_viterbi_decoder_tb
//   Self-checking bench for viterbi_decoder_tb. A behavioural encoder built
//   from the generator equations (tail-biting via modulo indexing) produces
//   the coded FIFO contents. The decoded bytes must reproduce the payload.
//   Block lengths are shrunk to 64/128 bits so the whole run stays short;
//   the decoder is length-agnostic apart from RAM sizing.
// ---------------------------------------------------------------------------
module tb_viterbi_decoder_tb;

    localparam int KS = 64;
    localparam int KL = 128;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       blk_len_sel = 1'b0;
    logic [2:0] in_empty;
    logic       in_rdreq;
    logic [7:0] in_q0 = 8'h00, in_q1 = 8'h00, in_q2 = 8'h00;
    logic       out_full = 1'b0;
    logic       out_wrreq;
    logic [7:0] out_data;
    logic       busy, done;

    viterbi_decoder_tb #(.K_SMALL(KS), .K_LARGE(KL), .PM_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .blk_len_sel(blk_len_sel),
        .in_empty(in_empty), .in_rdreq(in_rdreq),
        .in_q0(in_q0), .in_q1(in_q1), .in_q2(in_q2),
        .out_full(out_full), .out_wrreq(out_wrreq), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Input FIFO model: three byte arrays behind one read pointer.
    logic [7:0] fifo0 [KL/8];
    logic [7:0] fifo1 [KL/8];
    logic [7:0] fifo2 [KL/8];
    int         fifo_len = 0;
    int         rd_ptr = 0;
    logic [2:0] block_mask = 3'b000;

    assign in_empty = {3{rd_ptr >= fifo_len}} | block_mask;

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 0;
        end else if (in_rdreq) begin
            if (rd_ptr < fifo_len) begin
                in_q0 <= fifo0[rd_ptr];
                in_q1 <= fifo1[rd_ptr];
                in_q2 <= fifo2[rd_ptr];
            end
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Output collection and protocol monitors, sampled away from the clock edge.
    logic [7:0] out_buf [KL/8];
    int         out_cnt = 0;
    int         done_cnt = 0;
    int         rd_viol = 0;
    int         wr_viol = 0;

    always @(negedge clk) begin
        if (reset) begin
            out_cnt  = 0;
            done_cnt = 0;
        end else begin
            if (out_wrreq) begin
                if (out_cnt < KL/8) out_buf[out_cnt] = out_data;
                out_cnt++;
            end
            if (done) done_cnt++;
        end
        if (in_rdreq && in_empty != 3'b000) rd_viol++;
        if (out_wrreq && out_full) wr_viol++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference data
    bit         pay [KL];
    logic [7:0] exp_bytes [KL/8];

    // Encode pay[0..k-1] into the FIFOs. The tail-biting start state is the
    // block's last six bits, which modulo indexing gives directly.
    // err_fifo >= 0 flips coded bit err_bit of that sub-block.
    task automatic encode_payload(input int k, input int err_fifo, input int err_bit);
        bit u [7];
        for (int j = 0; j < KL/8; j++) begin
            fifo0[j] = 8'h00; fifo1[j] = 8'h00; fifo2[j] = 8'h00;
            exp_bytes[j] = 8'h00;
        end
        for (int n = 0; n < k; n++) begin
            for (int d = 0; d < 7; d++) u[d] = pay[(n - d + k) % k];
            fifo0[n/8][n%8] = u[0] ^ u[2] ^ u[3] ^ u[5] ^ u[6];
            fifo1[n/8][n%8] = u[0] ^ u[1] ^ u[2] ^ u[3] ^ u[6];
            fifo2[n/8][n%8] = u[0] ^ u[1] ^ u[2] ^ u[4] ^ u[6];
            exp_bytes[n/8][7 - n%8] = pay[n];
        end
        if (err_fifo == 0) fifo0[err_bit/8][err_bit%8] = ~fifo0[err_bit/8][err_bit%8];
        if (err_fifo == 1) fifo1[err_bit/8][err_bit%8] = ~fifo1[err_bit/8][err_bit%8];
        if (err_fifo == 2) fifo2[err_bit/8][err_bit%8] = ~fifo2[err_bit/8][err_bit%8];
        fifo_len = k / 8;
    endtask

    // Literal single-impulse pattern: payload 0x80 followed by zeros.
    task automatic load_impulse(input bit flip_q1);
        for (int j = 0; j < KL/8; j++) begin
            fifo0[j] = 8'h00; fifo1[j] = 8'h00; fifo2[j] = 8'h00;
            exp_bytes[j] = 8'h00;
        end
        fifo0[0] = 8'h6D; fifo1[0] = 8'h4F; fifo2[0] = 8'h57;
        if (flip_q1) fifo1[5] = fifo1[5] ^ 8'h08;
        exp_bytes[0] = 8'h80;
        fifo_len = KS / 8;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_negedges_until_pops(input int pops, input int limit, input string tag);
        int cyc = 0;
        while (rd_ptr < pops && cyc < limit) begin @(negedge clk); cyc++; end
        check(tag, (rd_ptr >= pops), 1);
    endtask

    // mode: 0 plain, 1 input/output stalls, 2 extra start while busy
    task automatic run_block(input string name, input bit sel, input int k, input int mode);
        int limit, cyc, cnt_before;
        limit = 80 * k + 2000;
        @(posedge clk); #1;
        blk_len_sel = sel;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, " busy_after_start"}, busy, 1);
        if (mode == 2) begin
            wait_negedges_until_pops(2, limit, {name, " pops_reached"});
            @(posedge clk); #1;
            blk_len_sel = ~sel;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
        end
        if (mode == 1) begin
            wait_negedges_until_pops(5, limit, {name, " pops_reached"});
            @(posedge clk); #1;
            block_mask = 3'b010;
            cnt_before = rd_ptr;
            repeat (600) @(posedge clk);
            #1;
            check({name, " no_pop_while_empty"}, rd_ptr - cnt_before, 0);
            block_mask = 3'b000;
            cyc = 0;
            while (out_cnt == 0 && cyc < limit) begin @(negedge clk); cyc++; end
            @(posedge clk); #1;
            out_full = 1'b1;
            cnt_before = out_cnt;
            repeat (100) @(posedge clk);
            #1;
            check({name, " no_push_while_full"}, out_cnt - cnt_before, 0);
            out_full = 1'b0;
        end
        cyc = 0;
        while (done_cnt == 0 && cyc < limit) begin @(negedge clk); cyc++; end
        check({name, " done_seen"}, (done_cnt != 0), 1);
        repeat (4) @(negedge clk);
        check({name, " done_pulses"}, done_cnt, 1);
        check({name, " busy_after_done"}, busy, 0);
        check({name, " byte_count"}, out_cnt, k / 8);
        check({name, " pops"}, rd_ptr, k / 8);
        for (int j = 0; j < k / 8; j++)
            check($sformatf("%s byte%0d", name, j), out_buf[j], exp_bytes[j]);
    endtask

    initial begin
        int err_pos;
        do_reset();
        @(negedge clk);
        check("reset in_rdreq", in_rdreq, 0);
        check("reset out_wrreq", out_wrreq, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset out_data", out_data, 0);

        // 1: all-zero coded input
        for (int i = 0; i < KL; i++) pay[i] = 1'b0;
        encode_payload(KS, -1, 0);
        do_reset();
        run_block("t1_zero", 1'b0, KS, 0);

        // 2: single impulse from literal coded bytes
        load_impulse(1'b0);
        do_reset();
        run_block("t2_impulse", 1'b0, KS, 0);

        // 3: same with one flipped bit in q1 byte 5
        load_impulse(1'b1);
        do_reset();
        run_block("t3_err", 1'b0, KS, 0);

        // 4: long block, random payload, start re-pulsed while busy
        for (int i = 0; i < KL; i++) pay[i] = 1'($urandom_range(0, 1));
        encode_payload(KL, -1, 0);
        do_reset();
        run_block("t4_rand_long", 1'b1, KL, 2);

        // 5: impulse with input starvation and output back-pressure
        load_impulse(1'b0);
        do_reset();
        run_block("t5_stall", 1'b0, KS, 1);
        check("t5 rdreq_while_empty", rd_viol, 0);
        check("t5 wrreq_while_full", wr_viol, 0);

        // 6: reset in mid-ACS around step 30, then a clean rerun
        load_impulse(1'b0);
        do_reset();
        @(posedge clk); #1;
        blk_len_sel = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_negedges_until_pops(4, 8000, "t6 pops_reached");
        repeat (390) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        check("t6 reset busy", busy, 0);
        check("t6 reset in_rdreq", in_rdreq, 0);
        check("t6 reset out_wrreq", out_wrreq, 0);
        check("t6 reset done", done, 0);
        check("t6 reset out_data", out_data, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        run_block("t6_rerun", 1'b0, KS, 0);

        // 7: random short payload with one random channel error
        for (int i = 0; i < KL; i++) pay[i] = 1'($urandom_range(0, 1));
        err_pos = int'($urandom_range(0, KS - 1));
        encode_payload(KS, int'($urandom_range(0, 2)), err_pos);
        do_reset();
        run_block("t7_rand_err", 1'b0, KS, 0);

        check("protocol rdreq_while_empty", rd_viol, 0);
        check("protocol wrreq_while_full", wr_viol, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
